// File: rtl/turfio_cin_pkg.sv
// turfio_cin_pkg: shared types and constants for the SURF CIN capture path
package turfio_cin_pkg;
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} cin_cap_state_t;
  localparam logic [31:0] CIN_TRAIN_PATTERN = 32'hA55A6996;
  localparam int CIN_WORD_NIBBLES = 8;
endpackage

// File: rtl/turfio_cin_capture_if.sv
// turfio_cin_capture_if: aligned command word bus and link status toward decoder/registers
interface turfio_cin_capture_if;
  logic [31:0] cin_word_o;
  logic        cin_valid_o;
  logic        locked_o;
  logic [1:0]  bit_offset_o;
  logic [2:0]  nibble_phase_o;
  logic [15:0] err_cnt_o;
  modport master(output cin_word_o, cin_valid_o, locked_o, bit_offset_o, nibble_phase_o, err_cnt_o);
  modport slave(input cin_word_o, cin_valid_o, locked_o, bit_offset_o, nibble_phase_o, err_cnt_o);
endinterface

// File: rtl/turfio_cin_aligner.sv
// turfio_cin_aligner: 35-bit nibble window, 4-offset pattern compare and word select
module turfio_cin_aligner
  import turfio_cin_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = CIN_TRAIN_PATTERN
) (
  input  logic        rxclk_i,
  input  logic        rst_n_i,
  input  logic [3:0]  data_i,
  input  logic [1:0]  sel,
  output logic [3:0]  match,
  output logic [31:0] word
);
  logic [34:0] win;
  // oldest bit sits at win[34]; data_i[0] arrived first so it lands highest
  always_ff @(posedge rxclk_i or negedge rst_n_i)
    if (!rst_n_i) win <= '0;
    else win <= {win[30:0], data_i[0], data_i[1], data_i[2], data_i[3]};
  for (genvar b = 0; b < 4; b++) begin : g_cmp
    assign match[b] = win[34-b -: 32] == TRAIN_PATTERN;
  end
  assign word = 32'(win >> (2'd3 - sel));
endmodule

// File: rtl/turfio_cin_capture.sv
// turfio_cin_capture: CIN word alignment/lock FSM; error counter built when TURFIO_CIN_CAPTURE_ERRCNT_EN is defined
module turfio_cin_capture
  import turfio_cin_pkg::*;
#(
  parameter logic [31:0] TRAIN_PATTERN = CIN_TRAIN_PATTERN,
  parameter int          LOCK_COUNT    = 4
) (
  input  logic       rxclk_i,
  input  logic       rst_n_i,
  input  logic [3:0] data_i,
  input  logic       train_en_i,
  input  logic       relock_i,
  turfio_cin_capture_if.master cin
);
  localparam logic [3:0] LC = 4'(LOCK_COUNT);
  cin_cap_state_t state, state_n;
  logic [3:0]  match;
  logic [31:0] word;
  logic [1:0]  b_sel, b_n, hunt_b, rst_sync;
  logic [2:0]  nib_cnt, phase, phase_n;
  logic [3:0]  match_cnt, match_n, miss_cnt, miss_n;
  logic        hit, boundary, err_inc, valid_n;

  turfio_cin_aligner #(.TRAIN_PATTERN(TRAIN_PATTERN)) u_align (
    .rxclk_i(rxclk_i),
    .rst_n_i(rst_n_i),
    .data_i(data_i),
    .sel(b_sel),
    .match(match),
    .word(word)
  );

  assign hunt_b   = match[0] ? 2'd0 : match[1] ? 2'd1 : match[2] ? 2'd2 : 2'd3;
  assign hit      = match[b_sel];
  assign boundary = nib_cnt == phase;
  assign valid_n  = state_n == LOCKED && nib_cnt == phase_n;

  // next state: hunt every cycle, verify/track only on word boundaries; relock overrides
  always_comb begin
    state_n = state;
    b_n     = b_sel;
    phase_n = phase;
    match_n = match_cnt;
    miss_n  = miss_cnt;
    err_inc = 1'b0;
    case (state)
      HUNT: if (rst_sync[1] && |match) begin
        b_n     = hunt_b;
        phase_n = nib_cnt;
        match_n = 4'd1;
        miss_n  = '0;
        state_n = LC == 4'd1 ? LOCKED : CHECK;
      end
      CHECK: if (boundary) begin
        match_n = match_cnt + 4'd1;
        state_n = !hit ? HUNT : match_n == LC ? LOCKED : CHECK;
      end
      LOCKED: if (boundary && train_en_i) begin
        miss_n  = hit ? '0 : miss_cnt + 4'd1;
        err_inc = !hit;
        state_n = miss_n == LC ? HUNT : LOCKED;
      end
      default: state_n = HUNT;
    endcase
    if (relock_i) begin
      state_n = HUNT;
      match_n = '0;
      miss_n  = '0;
    end
  end

  // state, alignment, counters and the registered word strobe
  always_ff @(posedge rxclk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state           <= HUNT;
      rst_sync        <= '0;
      nib_cnt         <= '0;
      b_sel           <= '0;
      phase           <= '0;
      match_cnt       <= '0;
      miss_cnt        <= '0;
      cin.cin_valid_o <= 1'b0;
      cin.cin_word_o  <= '0;
    end else begin
      state           <= state_n;
      rst_sync        <= {rst_sync[0], 1'b1};
      nib_cnt         <= nib_cnt + 3'd1;
      b_sel           <= b_n;
      phase           <= phase_n;
      match_cnt       <= match_n;
      miss_cnt        <= miss_n;
      cin.cin_valid_o <= valid_n;
      if (valid_n) cin.cin_word_o <= word;
    end

  assign cin.locked_o       = state == LOCKED;
  assign cin.bit_offset_o   = b_sel;
  assign cin.nibble_phase_o = phase;

`ifdef TURFIO_CIN_CAPTURE_ERRCNT_EN
  logic [15:0] err_cnt;
  // saturating mismatch count, cleared only by relock or reset
  always_ff @(posedge rxclk_i or negedge rst_n_i)
    if (!rst_n_i) err_cnt <= '0;
    else if (relock_i) err_cnt <= '0;
    else if (err_inc && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
  assign cin.err_cnt_o = err_cnt;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign cin.err_cnt_o  = '0;
`endif
endmodule

// File: tb/tb_turfio_cin_capture.sv
// tb_turfio_cin_capture: table-driven word-slot checks of alignment, lock, error and relock behaviour
module tb_turfio_cin_capture;
  localparam logic [31:0] P = 32'hA55A6996;
  localparam logic [31:0] X = 32'h5AA59669;
`ifdef TURFIO_CIN_CAPTURE_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] w;
    bit te;
    bit v;
    bit lk;
    bit rl;
    int err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n_i;
  logic [3:0] data_i;
  logic train_en_i;
  logic relock_i;
  int n_tests = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit bq[$];
  vec_t tv[$];

  turfio_cin_capture_if cif();

  turfio_cin_capture #(.TRAIN_PATTERN(32'hA55A6996), .LOCK_COUNT(4)) dut (
    .rxclk_i(clk),
    .rst_n_i(rst_n_i),
    .data_i(data_i),
    .train_en_i(train_en_i),
    .relock_i(relock_i),
    .cin(cif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " locked"}, 32'(cif.locked_o), 32'd0);
    chk({nm, " valid"}, 32'(cif.cin_valid_o), 32'd0);
    chk({nm, " word"}, cif.cin_word_o, 32'd0);
    chk({nm, " offset"}, 32'(cif.bit_offset_o), 32'd0);
    chk({nm, " phase"}, 32'(cif.nibble_phase_o), 32'd0);
    chk({nm, " err"}, 32'(cif.err_cnt_o), 32'd0);
  endtask

  task automatic add(input logic [31:0] w, input bit te, input bit v, input bit lk, input int err, input bit rl);
    tv.push_back('{w: w, te: te, v: v, lk: lk, rl: rl, err: err});
  endtask

  task automatic load_nib();
    for (int i = 0; i < 4; i++) data_i[i] = bq.size() > 0 ? bq.pop_front() : 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    edge_n++;
    load_nib();
  endtask

  // 19 pad bits place every word at bit offset 2 with its last nibble sampled on edge 13+8j (phase 5)
  task automatic restart(input string nm);
    rst_n_i = 1'b0;
    relock_i = 1'b0;
    train_en_i = 1'b1;
    data_i = '0;
    bq.delete();
    repeat (2) @(negedge clk);
    chk_zero({nm, " reset"});
    for (int i = 0; i < 19; i++) bq.push_back(1'b0);
    foreach (tv[j]) for (int i = 31; i >= 0; i--) bq.push_back(tv[j].w[i]);
    rst_n_i = 1'b1;
    load_nib();
    edge_n = 0;
  endtask

  task automatic run_tv(input string nm);
    logic lk;
    int s, j, n;
    restart(nm);
    lk = 1'b0;
    n = 14 + 8 * (tv.size() - 1);
    for (int e = 1; e <= n; e++) begin
      cyc();
      s = e - 13;
      if (s >= 0 && s % 8 == 0 && s / 8 < tv.size()) begin
        train_en_i = tv[s/8].te;
        relock_i = 1'b0;
        if (tv[s/8].rl) begin
          lk = 1'b0;
          chk({nm, " relock err"}, 32'(cif.err_cnt_o), 32'd0);
        end
      end
      if (s >= -1 && (s + 1) % 8 == 0 && (s + 1) / 8 < tv.size()) relock_i = tv[(s+1)/8].rl;
      s = e - 14;
      if (s >= 0 && s % 8 == 0) begin
        j = s / 8;
        lk = tv[j].lk;
        chk($sformatf("%s w%0d valid", nm, j), 32'(cif.cin_valid_o), 32'(tv[j].v));
        chk($sformatf("%s w%0d err", nm, j), 32'(cif.err_cnt_o), ERR_EN ? 32'(tv[j].err) : 32'd0);
        if (tv[j].v) begin
          chk($sformatf("%s w%0d word", nm, j), cif.cin_word_o, tv[j].w);
          chk($sformatf("%s w%0d offset", nm, j), 32'(cif.bit_offset_o), 32'd2);
          chk($sformatf("%s w%0d phase", nm, j), 32'(cif.nibble_phase_o), 32'd5);
        end
      end else begin
        chk($sformatf("%s e%0d valid", nm, e), 32'(cif.cin_valid_o), 32'd0);
      end
      chk($sformatf("%s e%0d locked", nm, e), 32'(cif.locked_o), 32'(lk));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tv.delete();
    add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0);
    add(P, 1, 1, 1, 0, 0); add(P, 1, 1, 1, 0, 0);
    add(32'h12345678, 0, 1, 1, 0, 0); add(32'hDEADBEEF, 0, 1, 1, 0, 0);
    add(P, 1, 1, 1, 0, 0);
    add(X, 1, 1, 1, 1, 0); add(P, 1, 1, 1, 1, 0);
    add(X, 1, 1, 1, 2, 0); add(X, 1, 1, 1, 3, 0); add(X, 1, 1, 1, 4, 0); add(X, 1, 0, 0, 5, 0);
    add(P, 1, 0, 0, 5, 0); add(P, 1, 0, 0, 5, 0); add(P, 1, 0, 0, 5, 0); add(P, 1, 1, 1, 5, 0);
    run_tv("lock");

    #3;
    rst_n_i = 1'b0;
    #1;
    chk_zero("async");

    tv.delete();
    add(P, 1, 0, 0, 0, 0); add(X, 1, 0, 0, 0, 0);
    add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0);
    add(P, 1, 1, 1, 0, 0); add(P, 1, 1, 1, 0, 0);
    run_tv("check");

    tv.delete();
    add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0);
    add(P, 1, 1, 1, 0, 0);
    add(X, 1, 1, 1, 1, 0); add(P, 1, 1, 1, 1, 0);
    add(X, 1, 1, 1, 2, 0); add(P, 1, 1, 1, 2, 0);
    add(X, 1, 1, 1, 3, 0); add(P, 1, 1, 1, 3, 0);
    add(P, 1, 0, 0, 0, 1); add(P, 1, 0, 0, 0, 0); add(P, 1, 0, 0, 0, 0);
    add(P, 1, 1, 1, 0, 0);
    run_tv("relock");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/turfio_cin_capture.md
# turfio_cin_capture

Word-alignment and capture stage for the SURF CIN command link. Consumes the 4-bit-per-rxclk nibble stream produced by the CIN ISERDES, hunts for the 32-bit training pattern across all 32 bit/nibble alignments, and verifies lock. Once locked, it delivers one aligned 32-bit command word every 8 rxclk cycles to the SURF command decoder. Alignment status and error counts feed the TURFIO control register space.

## Interface
Parameters:
- `TRAIN_PATTERN`, 32'hA55A6996: training word, first transmitted bit = MSB.
- `LOCK_COUNT`, 4: consecutive matching words required to lock, and consecutive mismatches required to unlock; range 1–15.

Ports:
- `rxclk_i` input 1: rxclk, the single clock.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `data_i` input 4: ISERDES nibble; `data_i[0]` is the earliest-received bit.
- `train_en_i` input 1: link in training; enables pattern checking while LOCKED.
- `relock_i` input 1: single-cycle pulse; forces HUNT and clears the error count.
- `cin_word_o` output 32: aligned word; first-received bit in [31].
- `cin_valid_o` output 1: one-cycle strobe qualifying `cin_word_o`.
- `locked_o` output 1: state == LOCKED.
- `bit_offset_o` output 2: selected bit offset.
- `nibble_phase_o` output 3: selected nibble phase.
- `err_cnt_o` output 16: saturating training-mismatch count.

## Operation
- Window: a 35-bit shift register takes in `data_i` every cycle. A candidate word at bit offset b (0–3) is the 32 bits starting b bits into the window. A free-running 3-bit nibble counter increments every cycle and wraps 7→0.
- States: HUNT, CHECK, LOCKED.
- Reset: enter HUNT. All outputs are 0, the counters are 0, and the window is 0.
- HUNT: every cycle, compare all 4 offsets against `TRAIN_PATTERN`. On a match, latch b (lowest b wins on multiple matches) and phase p = current nibble count. Set match count = 1. Go to CHECK.
- CHECK: compare only at word boundaries, where nibble count == p. On a match, increment match count; when it reaches `LOCK_COUNT`, go to LOCKED. On a mismatch, return to HUNT. If `LOCK_COUNT` == 1, go straight from HUNT to LOCKED.
- LOCKED:
  - Emit `cin_valid_o` at every boundary.
  - With `train_en_i` high, check each boundary word. A mismatch increments `err_cnt_o` (saturating at 16'hFFFF) and the miss count. A match clears the miss count. A miss count reaching `LOCK_COUNT` returns to HUNT; the error count is kept.
  - With `train_en_i` low, words pass through unchecked.
- `relock_i` takes effect in any state: next state HUNT, error count cleared, miss and match counts cleared. This has priority over the same-cycle transition.
- `bit_offset_o` and `nibble_phase_o` hold their last latched values outside LOCKED.
- `cin_word_o` updates only on valid strobes and otherwise holds.

## Timing
- Latency: the word whose final nibble is sampled on `data_i` at edge k appears on `cin_word_o` with `cin_valid_o` high in the cycle after edge k+1. Latency is 2 clocks.
- In LOCKED, `cin_valid_o` strobes exactly every 8 cycles and is never back-to-back.
- `locked_o` asserts in the same cycle as the first valid strobe of LOCKED. That strobe carries the `LOCK_COUNT`-th matching word.
- Minimum lock time from the first clean pattern word: 8·(`LOCK_COUNT`−1)+2 cycles.
- A `relock_i` asserted at edge k gives `locked_o` = 0 and `cin_valid_o` = 0 from cycle k+1 onward.
- Reset release is synchronized internally (2-flop) before the state machine leaves HUNT.

## Configuration
- `TURFIO_CIN_CAPTURE_ERRCNT_EN` defined: the 16-bit saturating error counter is built as described.
- Macro undefined: `err_cnt_o` is tied to 0. Mismatch detection and unlock behaviour are unchanged.

## Structure
- Shared package `turfio_cin_pkg`:
  - state enum `cin_cap_state_t` (HUNT, CHECK, LOCKED)
  - default `TRAIN_PATTERN` constant
  - `CIN_WORD_NIBBLES = 8`
- One sub-module, `turfio_cin_aligner`: the 35-bit window plus the 4-offset comparator and mux, which returns a match vector and the selected word. The FSM and counters stay at the top level.

## Test plan
- Pattern stream at b=2, p=5, `LOCK_COUNT`=4: `locked_o` rises 26 cycles after the first full pattern word; `bit_offset_o`=2, `nibble_phase_o`=5; `cin_word_o`=32'hA55A6996 on every strobe.
- Lock, then `train_en_i`=0 and send 32'h12345678, 32'hDEADBEEF: both emitted in order at 8-cycle spacing, `err_cnt_o` stays 0.
- Lock, `train_en_i`=1, one corrupted word: `err_cnt_o`=1, stays LOCKED. Four consecutive corrupted words: `err_cnt_o`=5, `locked_o` falls, re-hunts and relocks when clean data resumes.
- In CHECK, corrupt the 2nd word: returns to HUNT with no valid strobe; relocks later at the same b and p.
- Pulse `relock_i` while LOCKED with `err_cnt_o`=3: next cycle `locked_o`=0 and `err_cnt_o`=0; relocks within 26 cycles.
- Assert `rst_n_i` low mid-word: all outputs are 0 immediately (asynchronous). After release and clean input, the first lock occurs at the correct alignment.
